// File: rtl/read_pointer_control.sv
// rtl/read_pointer_control.sv - elastic buffer read-side pointer, fill/run control and SKP repeat
//
// Purpose:
//    Read-domain half of an elastic buffer. The writer's Gray pointer is
//    brought across with a two-flop synchronizer. The synchronized pointer is
//    then used to derive occupancy, to hold reading until the buffer has
//    filled, to request SKP deletion when the buffer runs full, and
//    (optionally) to repeat a SKP symbol when the buffer runs low.
//
// Ports:
//    read_clk           in   read-domain clock (only clock of the block)
//    rst_n              in   asynchronous active-low reset
//    gray_write_pointer in   [ADDR:0] writer Gray pointer, unsynchronized
//    rd_data            in   [DATA_WIDTH-1:0] buffer symbol at read_address
//    read_address       out  [ADDR:0] binary read pointer, MSB is the wrap bit
//    gray_read_pointer  out  [ADDR:0] Gray form of read_address
//    rd_valid           out  rd_data holds a valid symbol this cycle
//    underflow          out  buffer empty while reading
//    delete_req         out  registered request to drop the next SKP on write side
//    skp_inserted       out  one-cycle pulse, current SKP was repeated
//
// Configuration:
//    RD_SKP_INSERT_EN   defined: SKP repeat on low occupancy is built in;
//                       undefined: no repeat logic, skp_inserted tied low.

module read_pointer_control #(
   parameter int DATA_WIDTH   = 10,
   parameter int BUFFER_DEPTH = 16,
   parameter int FILL_LEVEL   = 8,
   parameter int LOW_THRESH   = 6,
   parameter int HIGH_THRESH  = 10,
   localparam int ADDR        = $clog2(BUFFER_DEPTH)
) (
   input  logic                  read_clk,
   input  logic                  rst_n,
   input  logic [ADDR:0]         gray_write_pointer,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR:0]         read_address,
   output logic [ADDR:0]         gray_read_pointer,
   output logic                  rd_valid,
   output logic                  underflow,
   output logic                  delete_req,
   output logic                  skp_inserted
);

   localparam logic [ADDR:0] FILL_L = (ADDR+1)'(FILL_LEVEL);
   localparam logic [ADDR:0] HIGH_L = (ADDR+1)'(HIGH_THRESH);

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [ADDR:0] sync_meta;
   logic [ADDR:0] sync_gwp;
   logic [ADDR:0] write_bin;
   logic [ADDR:0] level;
   logic          empty;
   logic          running;
   logic          insert_now;
   logic          advance;

   function automatic logic [ADDR:0] gray_to_bin(input logic [ADDR:0] g);
      logic [ADDR:0] b;
      b[ADDR] = g[ADDR];
      for (int i = ADDR - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Occupancy: modular difference keeps the wrap bit meaningful, so a full
   // buffer (level == BUFFER_DEPTH) is distinct from an empty one.
   assign gray_read_pointer = read_address ^ (read_address >> 1);
   assign write_bin         = gray_to_bin(sync_gwp);
   assign level             = write_bin - read_address;
   assign empty             = (sync_gwp == gray_read_pointer);
   assign running           = (state_q == ST_RUN);

   assign rd_valid  = running && !empty;
   // rst_n term keeps underflow low during the reset window itself.
   assign underflow = rst_n && running && empty;

`ifdef RD_SKP_INSERT_EN
   localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b0011111001);
   localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b1100000110);
   localparam logic [ADDR:0]         LOW_L   = (ADDR+1)'(LOW_THRESH);

   logic ins_done;
   logic is_skp;

   assign is_skp = (rd_data == SKP_POS) || (rd_data == SKP_NEG);

   // ins_done limits each SKP to a single repeat even if level stays low.
   assign insert_now = running && !empty && is_skp && (level < LOW_L) && !ins_done;

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_done     <= 1'b0;
         skp_inserted <= 1'b0;
      end else begin
         skp_inserted <= insert_now;
         if (insert_now) begin
            ins_done <= 1'b1;
         end else if (advance) begin
            ins_done <= 1'b0;
         end
      end
   end
`else
   logic unused_rd_data;

   assign unused_rd_data = ^rd_data;
   assign insert_now     = 1'b0;
   assign skp_inserted   = 1'b0;
`endif

   assign advance = running && !empty && !insert_now;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: if (level >= FILL_L) state_d = ST_RUN;
         ST_RUN:  if (empty)           state_d = ST_FILL;
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta    <= '0;
         sync_gwp     <= '0;
         state_q      <= ST_FILL;
         read_address <= '0;
         delete_req   <= 1'b0;
      end else begin
         sync_meta  <= gray_write_pointer;
         sync_gwp   <= sync_meta;
         state_q    <= state_d;
         delete_req <= (level > HIGH_L);
         if (advance) begin
            read_address <= read_address + 1'b1;
         end
      end
   end

endmodule
